// File: rtl/input_debouncer.sv
// Two-stage-minimum synchroniser followed by a STABLE/CONFIRM debounce FSM.
// Produces a clean registered level, a confirm-in-progress flag and a bounce-reject pulse.
module input_debouncer #(
  parameter int   SyncStages   = 2,
  parameter int   StableCycles = 16,
  parameter logic InitLevel    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic bouncing,
  output logic rejected
);

  localparam int             CW   = $clog2(StableCycles) + 1;
  localparam logic [CW-1:0]  LAST = CW'(StableCycles - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    CONFIRM = 1'b1
  } state_t;

  logic [SyncStages-1:0] sync_p0;
  logic                  synced;

  state_t        state_p1, state_d;
  logic [CW-1:0] cnt_p1, cnt_d;
  logic          level_p1, level_d;
  logic          rejected_p1, rejected_d;

  // Stage 0: synchroniser chain; only its last flop feeds the FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= {SyncStages{InitLevel}};
    end else begin
      sync_p0 <= {sync_p0[SyncStages-2:0], raw};
    end
  end

  assign synced = sync_p0[SyncStages-1];

  // Stage 1: debounce FSM registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1    <= STABLE;
      cnt_p1      <= '0;
      level_p1    <= InitLevel;
      rejected_p1 <= 1'b0;
    end else begin
      state_p1    <= state_d;
      cnt_p1      <= cnt_d;
      level_p1    <= level_d;
      rejected_p1 <= rejected_d;
    end
  end

  always_comb begin
    state_d    = state_p1;
    cnt_d      = cnt_p1;
    level_d    = level_p1;
    rejected_d = 1'b0;
    case (state_p1)
      STABLE: begin
        cnt_d = '0;
        if (synced != level_p1) begin
          if (StableCycles == 1) begin
            level_d = ~level_p1;
          end else begin
            state_d = CONFIRM;
            cnt_d   = CW'(1);
          end
        end
      end
      CONFIRM: begin
        if (synced == level_p1) begin
          state_d    = STABLE;
          cnt_d      = '0;
          rejected_d = 1'b1;
        end else if (cnt_p1 == LAST) begin
          // Confirming sample: the only cycle level may move while in CONFIRM
          state_d = STABLE;
          cnt_d   = '0;
          level_d = ~level_p1;
        end else begin
          cnt_d = cnt_p1 + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level    = level_p1;
  assign bouncing = (state_p1 == CONFIRM);
  assign rejected = rejected_p1;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: expected per-cycle level/bouncing/rejected triples are queued
// from hand-derived timing and popped against the DUT one clock after each stimulus step.
module tb_input_debouncer;

  typedef struct packed {
    logic l;
    logic b;
    logic r;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic raw_a, lvl_a, bnc_a, rej_a;
  logic raw_s, lvl_s, bnc_s, rej_s;
  logic raw_i, lvl_i, bnc_i, rej_i;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;
  int   ups = 0;
  int   downs = 0;
  logic prev_a = 1'b0;

  always #5 clk = ~clk;

  input_debouncer #(.SyncStages(2), .StableCycles(4), .InitLevel(1'b0)) dut_a (
    .clk(clk), .rst(rst), .raw(raw_a), .level(lvl_a), .bouncing(bnc_a), .rejected(rej_a)
  );
  input_debouncer #(.SyncStages(2), .StableCycles(1), .InitLevel(1'b0)) dut_s (
    .clk(clk), .rst(rst), .raw(raw_s), .level(lvl_s), .bouncing(bnc_s), .rejected(rej_s)
  );
  input_debouncer #(.SyncStages(2), .StableCycles(4), .InitLevel(1'b1)) dut_i (
    .clk(clk), .rst(rst), .raw(raw_i), .level(lvl_i), .bouncing(bnc_i), .rejected(rej_i)
  );

  // Downstream edge detector on the main instance's level
  always @(posedge clk) begin
    if (lvl_a === 1'b1 && prev_a === 1'b0) ups++;
    if (lvl_a === 1'b0 && prev_a === 1'b1) downs++;
    prev_a = lvl_a;
  end

  function automatic exp_t mk(input logic l, input logic b, input logic r);
    exp_t t;
    t.l = l;
    t.b = b;
    t.r = r;
    return t;
  endfunction

  task automatic test_reset();
    rst   = 1'b0;
    raw_a = 1'b0;
    raw_s = 1'b0;
    raw_i = 1'b1;
    #3 rst = 1'b1;
    #1;
    q.push_back(mk(1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b0, 1'b0, 1'b0));
    q.push_back(mk(1'b1, 1'b0, 1'b0));
    e = q.pop_front(); checks++;
    if ({lvl_a, bnc_a, rej_a} !== e) begin
      errors++; $display("FAIL reset_async_a: got %b%b%b want %b", lvl_a, bnc_a, rej_a, e);
    end
    e = q.pop_front(); checks++;
    if ({lvl_s, bnc_s, rej_s} !== e) begin
      errors++; $display("FAIL reset_async_s: got %b%b%b want %b", lvl_s, bnc_s, rej_s, e);
    end
    e = q.pop_front(); checks++;
    if ({lvl_i, bnc_i, rej_i} !== e) begin
      errors++; $display("FAIL reset_async_init1: got %b%b%b want %b", lvl_i, bnc_i, rej_i, e);
    end
    raw_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      q.push_back(mk(1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = q.pop_front(); checks++;
      if ({lvl_a, bnc_a, rej_a} !== e) begin
        errors++; $display("FAIL reset_hold step %0d: got %b%b%b want %b", i, lvl_a, bnc_a, rej_a, e);
      end
    end
    @(negedge clk);
    raw_a = 1'b0;
    rst   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q.push_back(mk(1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = q.pop_front(); checks++;
      if ({lvl_a, bnc_a, rej_a} !== e) begin
        errors++; $display("FAIL reset_release step %0d: got %b%b%b want %b", i, lvl_a, bnc_a, rej_a, e);
      end
    end
  endtask

  task automatic test_clean_edges();
    int u0, d0;
    u0 = ups;
    d0 = downs;
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 8; i++) begin
        q.push_back(mk((i >= 5) ? (ph == 0) : (ph == 1), (i >= 2 && i <= 4), 1'b0));
        @(negedge clk); raw_a = (ph == 0);
        @(posedge clk); #1;
        e = q.pop_front(); checks++;
        if ({lvl_a, bnc_a, rej_a} !== e) begin
          errors++;
          $display("FAIL clean_%s step %0d: got %b%b%b want %b", (ph == 0) ? "rise" : "fall", i, lvl_a, bnc_a, rej_a, e);
        end
      end
    end
    checks++;
    if (ups - u0 != 1) begin
      errors++; $display("FAIL edge_up_count: got %0d want 1", ups - u0);
    end
    checks++;
    if (downs - d0 != 1) begin
      errors++; $display("FAIL edge_down_count: got %0d want 1", downs - d0);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      q.push_back(mk(1'b0, (i == 2 || i == 3), (i == 4)));
      @(negedge clk); raw_a = (i < 2);
      @(posedge clk); #1;
      e = q.pop_front(); checks++;
      if ({lvl_a, bnc_a, rej_a} !== e) begin
        errors++; $display("FAIL bounce step %0d: got %b%b%b want %b", i, lvl_a, bnc_a, rej_a, e);
      end
    end
  endtask

  task automatic test_chatter();
    int rej_seen = 0;
    for (int i = 0; i < 18; i++) begin
      q.push_back(mk((i >= 15),
                     (i >= 2 && i <= 10 && (i % 2) == 0) || (i >= 12 && i <= 14),
                     (i >= 3 && i <= 11 && (i % 2) == 1)));
      @(negedge clk); raw_a = (i < 10) ? ((i % 2) == 0) : 1'b1;
      @(posedge clk); #1;
      if (rej_a === 1'b1) rej_seen++;
      e = q.pop_front(); checks++;
      if ({lvl_a, bnc_a, rej_a} !== e) begin
        errors++; $display("FAIL chatter step %0d: got %b%b%b want %b", i, lvl_a, bnc_a, rej_a, e);
      end
    end
    checks++;
    if (rej_seen != 5) begin
      errors++; $display("FAIL chatter_reject_count: got %0d want 5", rej_seen);
    end
  endtask

  task automatic test_reset_mid_confirm();
    // level is 1 after chatter; reset first to get back to a 0 baseline
    @(negedge clk); rst = 1'b1; raw_a = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      q.push_back(mk(1'b0, (i >= 2), 1'b0));
      @(negedge clk); raw_a = 1'b1;
      @(posedge clk); #1;
      e = q.pop_front(); checks++;
      if ({lvl_a, bnc_a, rej_a} !== e) begin
        errors++; $display("FAIL midconf_pre step %0d: got %b%b%b want %b", i, lvl_a, bnc_a, rej_a, e);
      end
    end
    #2 rst = 1'b1;
    #1;
    q.push_back(mk(1'b0, 1'b0, 1'b0));
    e = q.pop_front(); checks++;
    if ({lvl_a, bnc_a, rej_a} !== e) begin
      errors++; $display("FAIL midconf_in_reset: got %b%b%b want %b", lvl_a, bnc_a, rej_a, e);
    end
    raw_a = 1'b0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      q.push_back(mk(1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      e = q.pop_front(); checks++;
      if ({lvl_a, bnc_a, rej_a} !== e) begin
        errors++; $display("FAIL midconf_post step %0d: got %b%b%b want %b", i, lvl_a, bnc_a, rej_a, e);
      end
    end
  endtask

  task automatic test_stable1();
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 6; i++) begin
        q.push_back(mk((i >= 2) ? (ph == 0) : (ph == 1), 1'b0, 1'b0));
        @(negedge clk); raw_s = (ph == 0);
        @(posedge clk); #1;
        e = q.pop_front(); checks++;
        if ({lvl_s, bnc_s, rej_s} !== e) begin
          errors++; $display("FAIL stable1 ph %0d step %0d: got %b%b%b want %b", ph, i, lvl_s, bnc_s, rej_s, e);
        end
      end
    end
  endtask

  task automatic test_init1();
    for (int i = 0; i < 9; i++) begin
      q.push_back(mk((i < 5), (i >= 2 && i <= 4), 1'b0));
      @(negedge clk); raw_i = 1'b0;
      @(posedge clk); #1;
      e = q.pop_front(); checks++;
      if ({lvl_i, bnc_i, rej_i} !== e) begin
        errors++; $display("FAIL init1_fall step %0d: got %b%b%b want %b", i, lvl_i, bnc_i, rej_i, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_edges();
    test_bounce();
    test_chatter();
    test_reset_mid_confirm();
    test_stable1();
    test_init1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Synchronises and debounces one asynchronous, bouncy input (push-button, switch, external strobe) into a clean single-clock-domain level. It sits directly upstream of the edge-detection stage: its `level` output is the `D` input of the border detector, which then produces the one-cycle rise/fall pulses. It also reports when a candidate transition is in progress and when a candidate transition is rejected as a bounce.

## Interface

Parameters:
- `SyncStages`, default 2: number of synchroniser flip-flops. Legal range is 2 or more.
- `StableCycles`, default 16: number of consecutive synchronised samples of the new value required before `level` changes. Legal range is 1 or more.
- `InitLevel`, default 1'b0: reset value of the synchroniser chain and of `level`.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `raw`, input, 1: asynchronous, possibly bouncing input.
- `level`, output, 1: debounced, synchronised level. Registered.
- `bouncing`, output, 1: high while a candidate transition is being confirmed (state CONFIRM). Registered or state-decoded, glitch-free.
- `rejected`, output, 1: one-cycle pulse when a candidate transition is abandoned. Registered.

## Operation

- **Synchroniser.** `raw` shifts through `SyncStages` flip-flops. The last stage is `synced`. Only `synced` is used by the FSM. `raw` never reaches any other logic.
- **FSM states.** STABLE and CONFIRM. The counter `cnt` is `$clog2(StableCycles)+1` bits wide, unsigned, and never wraps.
- **STABLE, `synced == level`:** stay in STABLE, `cnt = 0`.
- **STABLE, `synced != level`:**
  - If `StableCycles == 1`: toggle `level` and stay in STABLE.
  - Otherwise: go to CONFIRM with `cnt = 1`.
- **CONFIRM, `synced == level` (bounced back):** go to STABLE, `cnt = 0`, and `rejected = 1` for the next cycle only.
- **CONFIRM, `synced != level` and `cnt == StableCycles-1`:** toggle `level`, go to STABLE, `cnt = 0`.
- **CONFIRM, `synced != level` otherwise:** `cnt = cnt + 1`.
- **`bouncing`** is 1 exactly when the state is CONFIRM.
- **`rejected`** is 0 in every cycle except the single cycle after an abort.
- **`level`** changes at most once per confirmed transition. It never toggles during CONFIRM, except on the confirming edge.

## Timing

- **Reset values:** all synchroniser stages = `InitLevel`, `level = InitLevel`, state = STABLE, `cnt = 0`, `bouncing = 0`, `rejected = 0`. These take effect immediately on `rst` assertion, independent of `clk`.
- **Reset mid-CONFIRM:** the transition is aborted silently, with no `rejected` pulse, either during reset or after release.
- **Latency.** Let E0 be the first clock edge that samples a new `raw` value, with `raw` held from then on. `level` takes the new value at edge E0 + SyncStages + StableCycles − 1.
  - Defaults: E0+17.
  - SyncStages=2, StableCycles=4: E0+5.
- **Minimum accepted pulse width:** `raw` must hold for StableCycles synchronised samples. Shorter pulses produce `bouncing` for their duration plus a `rejected` pulse, and `level` does not change.
- **Simultaneous events:** when the confirming sample and an opposite `raw` change arrive together, only the synchronised sample counts. Confirmation proceeds, then a new CONFIRM starts from STABLE.
- **Sustained toggling:** sustained `raw` toggling faster than StableCycles keeps `level` frozen. Each reversal seen in CONFIRM gives one `rejected` pulse.
- **Re-entry:** back-to-back confirmed transitions are allowed. After returning to STABLE, CONFIRM can be re-entered on the very next edge.
- **Downstream:** `level` is a clean registered signal. The downstream edge detector sees exactly one rise per confirmed 0→1 transition and one fall per confirmed 1→0 transition.

## Test plan

All scenarios use SyncStages=2, StableCycles=4, InitLevel=0 unless stated otherwise.

- **Reset state:** assert `rst` asynchronously between clock edges → `level = 0`, `bouncing = 0` and `rejected = 0` immediately. Hold `raw = 1` during reset → `level` stays 0 until release.
- **Clean rise:** set `raw` 0→1 before edge E0 and hold → `bouncing` is 1 after E2 through E4, and `level` = 1 after E5. Repeat for 1→0 → `level` = 0 after E5. The chained edge detector emits exactly one `up` pulse and one `down` pulse.
- **Bounce rejection:** `raw` is 1 for 2 cycles, then 0 → `bouncing` is 1 for 2 cycles, `rejected` is a single 1-cycle pulse, and `level` stays 0 throughout.
- **Chatter then settle:** `raw` toggles every cycle for 10 cycles, then holds at 1 → `level` stays 0 during the chatter, at least one `rejected` pulse occurs, and `level` = 1 exactly 5 edges after the final stable sampling edge.
- **Reset mid-CONFIRM:** assert `rst` with `cnt = 2` → state returns to STABLE, `level = 0`, and no `rejected` pulse occurs after release.
- **Parameter corners:** with StableCycles=1, `level` follows `raw` at E0+2 and `bouncing` never asserts. With InitLevel=1, reset gives `level = 1`, and the first 1→0 transition is confirmed at E0+5.
